// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop,
// producing diff = a - b - bin (mod 2^WIDTH) one bit per cycle, LSB first.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE or DONE; the edge on which it is
  // seen high captures a/b/bin, and done pulses for one cycle when diff/bout
  // hold the new result. start is ignored while busy.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             accept;
  logic             last_bit;
  logic             ai, bi, d, br_next;

  always_comb begin
    ai       = a_sr[0];
    bi       = b_sr[0];
    d        = ai ^ bi ^ borrow;
    br_next  = (~ai & bi) | (~(ai ^ bi) & borrow);
    last_bit = (cnt == CW'(WIDTH - 1));
    state_nx = state;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    bit_out  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        bit_out = d;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bit_valid = busy;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        borrow <= bin;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        borrow <= br_next;
        res_sr <= {d, res_sr[WIDTH-1:1]};
        cnt    <= cnt + 1'b1;
        // diff is published only once all bits are resolved.
        if (last_bit) begin
          diff <= {d, res_sr[WIDTH-1:1]};
          bout <= br_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed-vector bench for serial_full_subtractor (WIDTH=8): table-driven
// operations plus hand-written back-to-back, ignored-start and reset sequences.
module tb_serial_full_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, bit_out, bit_valid;
  logic [W-1:0] diff;
  logic [1:0]   state_dbg;

  int n_cmp;
  int n_err;
  logic [W-1:0] held_diff;
  logic         held_bout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs[9];

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout),
    .bit_out(bit_out), .bit_valid(bit_valid), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation with a single-cycle start pulse and check it end to end.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input logic [W-1:0] ediff, input logic ebout);
    logic [W-1:0] bits;
    int nbits;
    int lat;
    logic mid_ok;
    bits = '0;
    nbits = 0;
    lat = 0;
    mid_ok = 1'b1;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; bin = $urandom_range(0, 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (bit_valid) begin
        if (nbits < W) bits[nbits] = bit_out;
        nbits++;
        if (diff !== held_diff || bout !== held_bout) mid_ok = 1'b0;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    else check("latency", lat, W + 1);
    check("diff", diff, ediff);
    check("bout", bout, ebout);
    check("bit_count", nbits, W);
    check("bit_stream", bits, ediff);
    check("diff_held_midrun", mid_ok, 1'b1);
    held_diff = ediff;
    held_bout = ebout;
    @(negedge clk);
    check("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    held_diff = '0;
    held_bout = 1'b0;
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1};
    vecs[8] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, bout, bit_out, bit_valid}, 5'b0);
    check("reset_diff", diff, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);

    // start held high: accepted again in the DONE cycle, done every W+1 cycles
    begin
      int done_at[$];
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 2 * (W + 1); k++) begin
        @(negedge clk);
        if (done) begin
          done_at.push_back(k);
          check("b2b_diff", diff, 8'h00);
          check("b2b_bout", bout, 1'b0);
        end
        if (k == W + 2) check("b2b_busy_after_done", busy, 1'b1);
      end
      start = 1'b0;
      check("b2b_done_count", done_at.size(), 2);
      if (done_at.size() == 2) begin
        check("b2b_first_done", done_at[0], W + 1);
        check("b2b_second_done", done_at[1], 2 * (W + 1));
      end
      @(negedge clk);
      check("b2b_idle", {busy, done}, 2'b00);
      held_diff = 8'h00;
      held_bout = 1'b0;
    end

    // start re-pulsed mid-run with different operands is ignored
    begin
      int lat;
      lat = 0;
      @(negedge clk);
      a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 3) begin a = 8'h00; b = 8'h01; start = 1'b1; end
        else start = 1'b0;
        if (done) begin lat = k; break; end
      end
      check("ignore_latency", lat, W + 1);
      check("ignore_diff", diff, 8'h7F);
      check("ignore_bout", bout, 1'b0);
      start = 1'b0;
      @(negedge clk);
      check("ignore_no_restart", busy, 1'b0);
    end

    // reset mid-run aborts; no done pulse follows
    begin
      int seen_done;
      seen_done = 0;
      @(negedge clk);
      a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pre_busy", busy, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy_done", {busy, done, bit_valid, bit_out}, 4'b0);
      check("rst_diff", diff, 8'h00);
      check("rst_bout", bout, 1'b0);
      rst = 1'b0;
      repeat (2 * W) begin
        @(negedge clk);
        if (done || busy) seen_done++;
      end
      check("rst_no_done", seen_done, 0);
      held_diff = '0;
      held_bout = 1'b0;
    end

    // random operands against the (a - b - bin) & 0x1FF model
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rbin;
      logic [W:0] full;
      ra = $urandom; rb = $urandom; rbin = $urandom_range(0, 1);
      full = ({1'b0, ra} - {1'b0, rb} - {8'b0, rbin}) & 9'h1FF;
      if (full[W] !== ((32'(ra)) < (32'(rb) + 32'(rbin)))) begin
        $display("FAIL model_self: bout model disagrees for a=%0h b=%0h", ra, rb);
        n_err++;
      end
      run_op(ra, rb, rbin, full[W-1:0], full[W]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
